csa_cpa_serial: RTL and testbench
=================================

# csa_cpa_serial

Serial carry-propagate resolver that sits directly downstream of the 16-bit carry-save adder. It accepts one redundant-form result (sum vector, carry vector, MSB carry-out) per transaction and resolves it into a single binary value over WIDTH/CHUNK clock cycles using a CHUNK-bit adder slice. Valid/ready handshakes on both sides let it sit between the CSA tree and the consumer without a full-width carry chain.

## Interface
- WIDTH, 16: width of the sum and carry input vectors.
- CHUNK, 4: bits resolved per cycle. Must divide WIDTH; legal values are 1, 2, 4, 8, 16. Any other value is a configuration error.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand transfer request.
- in_ready  output  1  block can accept operands.
- sum  input  WIDTH  CSA sum vector (weight 2^i for bit i).
- carry  input  WIDTH  CSA carry vector (weight 2^i for bit i). Bit 0 is added like any other bit; a zero bit 0 is not required.
- of  input  1  CSA MSB carry-out, weight 2^WIDTH.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH+2  resolved value sum + carry + of·2^WIDTH.
- ovf  output  1  high when result[WIDTH+1:WIDTH] != 0, i.e. the value does not fit in WIDTH bits.

## Operation
- State machine: IDLE, RUN, DONE.
- **IDLE**
  - in_ready = 1, out_valid = 0.
  - On in_valid && in_ready: latch sum, carry and of; clear the chunk index and the carry register; go to RUN.
- **RUN** (one chunk per cycle)
  - in_ready = 0.
  - Each edge adds the current CHUNK-bit slice of sum and carry plus the carry register, writes the slice into the working result, and stores the slice carry-out into the carry register.
  - The slice index advances from LSB to MSB.
  - On the edge that processes the last slice (index WIDTH/CHUNK−1), compute the final result:
    - result[WIDTH-1:0] = the assembled slices.
    - result[WIDTH+1:WIDTH] = of + final slice carry-out, with a 2-bit range of 0..2.
    - ovf is updated with the result.
    - Go to DONE.
- **DONE**
  - out_valid = 1, in_ready = 0.
  - result and ovf are held stable.
  - On out_valid && out_ready, go to IDLE.
- result and ovf change only on the edge that enters DONE. After the handshake they keep their last value.
- in_valid while the block is not in IDLE is ignored; the operands are not sampled.
- Upper bound on the result: (2^WIDTH−1) + (2^WIDTH−1) + 2^WIDTH < 2^(WIDTH+2), so no overflow beyond WIDTH+2 bits is possible.
- **Reset** (asynchronous, active-low, valid at any time including mid-RUN or DONE):
  - Return to IDLE.
  - in_ready = 1, out_valid = 0, result = 0, ovf = 0.
  - Internal operand, carry and index registers are cleared; any in-flight transaction is discarded.

## Timing
- N = WIDTH/CHUNK. Defaults give N = 4.
- Edge E0: accept. Edges E1..EN: RUN. out_valid is high after edge EN, so latency from accept to out_valid is N cycles.
- An output handshake at edge EN+k (k ≥ 1) returns the block to IDLE. in_ready is high in the following cycle.
- Minimum transaction period is N+2 cycles. There is no overlap between consecutive transactions.
- in_ready and out_valid are registered state decodes. Neither output depends combinationally on in_valid or out_ready.
- The critical path is one CHUNK-bit adder plus the carry register.

## Test plan
- sum=0x1234, carry=0x0246, of=0, out_ready=1 → result=0x0147A, ovf=0; out_valid high exactly 4 cycles after accept; in_ready low during those cycles.
- sum=0xFFFF, carry=0xFFFE, of=1 → result=0x2FFFD, ovf=1.
- sum=0xFFFF, carry=0x0001, of=0 (carry ripples through all 4 slices) → result=0x10000, ovf=1.
- Same transaction as the first scenario, with out_ready held low for 5 cycles after out_valid and in_valid pulsed with sum=0xAAAA → result stays 0x0147A and in_ready stays 0; after out_ready goes high, the next accept sees new data and 0xAAAA is never processed.
- Assert rst_n low during the 2nd RUN cycle → immediately out_valid=0, in_ready=1, result=0; a fresh transaction afterwards (sum=0x0001, carry=0x0001) → result=0x00002 after 4 cycles.
- CHUNK=1 build, sum=0x8000, carry=0x8000, of=1 → result=0x20000, ovf=1, latency 16 cycles; CHUNK=16 build, same stimulus → same result, latency 1 cycle.

Source files
------------

// File: rtl/csa_cpa_serial.sv
// Serial carry-propagate resolver for a carry-save result.
// Ports: in_valid/in_ready + sum/carry/of in, out_valid/out_ready + result/ovf out.
module csa_cpa_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum,
  input  logic [WIDTH-1:0] carry,
  input  logic             of,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] result,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if ((CHUNK != 1 && CHUNK != 2 && CHUNK != 4 &&
       CHUNK != 8 && CHUNK != 16) ||
      (WIDTH % CHUNK) != 0) begin : g_cfg_err
    $error("csa_cpa_serial: illegal CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] carry_q, carry_d;
  logic             of_q, of_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH+1:0] result_q, result_d;
  logic             ovf_q, ovf_d;

  int unsigned      base;
  logic [CHUNK:0]   slice;
  logic [1:0]       hi;
  logic             last;

  always_comb begin
    base  = int'(idx_q) * CHUNK;
    slice = {1'b0, sum_q[base +: CHUNK]}
          + {1'b0, carry_q[base +: CHUNK]}
          + {{CHUNK{1'b0}}, cin_q};
    // Top two bits: MSB carry-out plus final slice carry, 0..2.
    hi    = {1'b0, of_q} + {1'b0, slice[CHUNK]};
    last  = (idx_q == IW'(N - 1));
  end

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    of_d     = of_q;
    idx_d    = idx_q;
    cin_d    = cin_q;
    work_d   = work_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sum_d   = sum;
          carry_d = carry;
          of_d    = of;
          idx_d   = '0;
          cin_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d[base +: CHUNK] = slice[CHUNK-1:0];
        cin_d = slice[CHUNK];
        idx_d = idx_q + IW'(1);
        if (last) begin
          result_d = {hi, work_d};
          ovf_d    = |hi;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sum_q    <= '0;
      carry_q  <= '0;
      of_q     <= 1'b0;
      idx_q    <= '0;
      cin_q    <= 1'b0;
      work_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      of_q     <= of_d;
      idx_q    <= idx_d;
      cin_q    <= cin_d;
      work_q   <= work_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_csa_cpa_serial.sv
// Directed bench for csa_cpa_serial (CHUNK 4, 1 and 16 builds).
// Table vectors plus backpressure, mid-run reset and latency sequences.
module tb_csa_cpa_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] s = '0;
  logic [15:0] c = '0;
  logic        o = 1'b0;

  logic        iv = 1'b0, ir, ov, ordy = 1'b1, vf;
  logic [17:0] res;
  logic        iv1 = 1'b0, ir1, ov1, vf1;
  logic [17:0] res1;
  logic        iv16 = 1'b0, ir16, ov16, vf16;
  logic [17:0] res16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csa_cpa_serial #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv), .in_ready(ir),
    .sum(s), .carry(c), .of(o),
    .out_valid(ov), .out_ready(ordy),
    .result(res), .ovf(vf)
  );

  csa_cpa_serial #(.WIDTH(16), .CHUNK(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv1), .in_ready(ir1),
    .sum(s), .carry(c), .of(o),
    .out_valid(ov1), .out_ready(1'b1),
    .result(res1), .ovf(vf1)
  );

  csa_cpa_serial #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv16), .in_ready(ir16),
    .sum(s), .carry(c), .of(o),
    .out_valid(ov16), .out_ready(1'b1),
    .result(res16), .ovf(vf16)
  );

  typedef struct {
    logic [15:0] s;
    logic [15:0] c;
    logic        o;
    logic [17:0] r;
    logic        v;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one transaction on the CHUNK=4 instance, wait for out_valid.
  task automatic run_main(input  logic [15:0] a,
                          input  logic [15:0] b,
                          input  logic        oi,
                          output logic [17:0] r,
                          output logic        v,
                          output int          lat,
                          output logic        busy_rdy);
    int t;
    t = 0;
    while (!ir && t < 20) begin
      step();
      t++;
    end
    s  = a;
    c  = b;
    o  = oi;
    iv = 1'b1;
    step();
    iv = 1'b0;
    lat = 0;
    busy_rdy = 1'b0;
    while (!ov && lat < 40) begin
      if (ir) busy_rdy = 1'b1;
      step();
      lat++;
    end
    r = res;
    v = vf;
  endtask

  logic [17:0] r;
  logic        v;
  int          lat;
  logic        br;

  initial begin
    vecs[0] = '{16'h1234, 16'h0246, 1'b0, 18'h0147A, 1'b0};
    vecs[1] = '{16'hFFFF, 16'hFFFE, 1'b1, 18'h2FFFD, 1'b1};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 18'h10000, 1'b1};
    vecs[3] = '{16'h0000, 16'h0000, 1'b0, 18'h00000, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b1, 18'h20000, 1'b1};
    vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 18'h01000, 1'b0};
    vecs[6] = '{16'hAAAA, 16'h5555, 1'b0, 18'h0FFFF, 1'b0};
    vecs[7] = '{16'h0000, 16'h0000, 1'b1, 18'h10000, 1'b1};

    step();
    step();
    chk("rst_in_ready", 32'(ir), 32'd1);
    chk("rst_out_valid", 32'(ov), 32'd0);
    chk("rst_result", 32'(res), 32'd0);
    chk("rst_ovf", 32'(vf), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      run_main(vecs[i].s, vecs[i].c, vecs[i].o, r, v, lat, br);
      chk($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].r));
      chk($sformatf("vec%0d_ovf", i), 32'(v), 32'(vecs[i].v));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_busy_ready", i), 32'(br), 32'd0);
      step();
      chk($sformatf("vec%0d_ready_after", i), 32'(ir), 32'd1);
    end

    // Backpressure: result held, in_valid ignored while not idle.
    ordy = 1'b0;
    run_main(16'h1234, 16'h0246, 1'b0, r, v, lat, br);
    chk("bp_result", 32'(r), 32'h0147A);
    chk("bp_latency", 32'(lat), 32'd4);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        s  = 16'hAAAA;
        iv = 1'b1;
      end
      step();
      iv = 1'b0;
      chk($sformatf("bp_hold%0d_result", k), 32'(res), 32'h0147A);
      chk($sformatf("bp_hold%0d_in_ready", k), 32'(ir), 32'd0);
      chk($sformatf("bp_hold%0d_out_valid", k), 32'(ov), 32'd1);
    end
    ordy = 1'b1;
    step();
    chk("bp_ready_after", 32'(ir), 32'd1);
    chk("bp_valid_after", 32'(ov), 32'd0);
    chk("bp_result_kept", 32'(res), 32'h0147A);
    run_main(16'h0003, 16'h0004, 1'b0, r, v, lat, br);
    chk("bp_next_result", 32'(r), 32'h00007);
    step();

    // Reset during the second RUN cycle.
    s  = 16'h1234;
    c  = 16'h0246;
    o  = 1'b0;
    iv = 1'b1;
    step();
    iv = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(ov), 32'd0);
    chk("mid_rst_in_ready", 32'(ir), 32'd1);
    chk("mid_rst_result", 32'(res), 32'd0);
    chk("mid_rst_ovf", 32'(vf), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    run_main(16'h0001, 16'h0001, 1'b0, r, v, lat, br);
    chk("post_rst_result", 32'(r), 32'h00002);
    chk("post_rst_latency", 32'(lat), 32'd4);
    step();

    // CHUNK=1 and CHUNK=16 builds, same stimulus.
    begin
      int l1, l16, cnt;
      logic [17:0] r1, r16;
      logic v1, v16;
      l1 = -1;
      l16 = -1;
      r1 = '0;
      r16 = '0;
      v1 = 1'b0;
      v16 = 1'b0;
      s = 16'h8000;
      c = 16'h8000;
      o = 1'b1;
      iv1 = 1'b1;
      iv16 = 1'b1;
      step();
      iv1 = 1'b0;
      iv16 = 1'b0;
      cnt = 0;
      while (cnt < 40 && (l1 < 0 || l16 < 0)) begin
        if (ov1 && l1 < 0) begin
          l1 = cnt;
          r1 = res1;
          v1 = vf1;
        end
        if (ov16 && l16 < 0) begin
          l16 = cnt;
          r16 = res16;
          v16 = vf16;
        end
        if (l1 < 0 || l16 < 0) begin
          step();
          cnt++;
        end
      end
      chk("c1_result", 32'(r1), 32'h20000);
      chk("c1_ovf", 32'(v1), 32'd1);
      chk("c1_latency", 32'(l1), 32'd16);
      chk("c16_result", 32'(r16), 32'h20000);
      chk("c16_ovf", 32'(v16), 32'd1);
      chk("c16_latency", 32'(l16), 32'd1);
    end

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
